// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: drives a valid/ready data-memory port, aligns and extends
// load data, and flags misaligned or illegal accesses without touching memory.
module load_store_unit #(
   parameter int unsigned REGISTER_WIDTH = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic                      i_req_is_store,
   input  logic [2:0]                i_req_funct3,
   input  logic [REGISTER_WIDTH-1:0] i_req_address,
   input  logic [REGISTER_WIDTH-1:0] i_req_store_data,
   input  logic [REG_ADDR_WIDTH-1:0] i_req_rd,
   output logic                      o_mem_valid,
   input  logic                      i_mem_ready,
   output logic [REGISTER_WIDTH-1:0] o_mem_address,
   output logic                      o_mem_write_en,
   output logic [3:0]                o_mem_byte_en,
   output logic [REGISTER_WIDTH-1:0] o_mem_write_data,
   input  logic [REGISTER_WIDTH-1:0] i_mem_read_data,
   input  logic                      i_mem_read_valid,
   output logic                      o_result_valid,
   output logic [REG_ADDR_WIDTH-1:0] o_result_rd,
   output logic [REGISTER_WIDTH-1:0] o_result_data,
   output logic                      o_store_done,
   output logic                      o_fault,
   output logic                      o_stall
);

   typedef enum logic [1:0] {StIdle, StMemReq, StWaitRd, StResp} state_t;

   state_t                    r_state;
   logic                      r_req_ready;
   logic                      r_mem_valid;
   logic [REGISTER_WIDTH-1:0] r_mem_address;
   logic                      r_mem_write_en;
   logic [3:0]                r_mem_byte_en;
   logic [REGISTER_WIDTH-1:0] r_mem_write_data;
   logic                      r_result_valid;
   logic [REG_ADDR_WIDTH-1:0] r_result_rd;
   logic [REGISTER_WIDTH-1:0] r_result_data;
   logic                      r_store_done;
   logic                      r_fault;
   logic                      r_is_store;
   logic [2:0]                r_funct3;
   logic [1:0]                r_off;
   logic [REG_ADDR_WIDTH-1:0] r_rd;

   logic                      w_legal;
   logic                      w_aligned;
   logic [3:0]                w_byte_en;
   logic [REGISTER_WIDTH-1:0] w_write_data;
   logic [REGISTER_WIDTH-1:0] w_shifted;
   logic [REGISTER_WIDTH-1:0] w_load_value;

   always_comb begin
      w_legal = 1'b0;
      case (i_req_funct3)
         3'b000, 3'b001, 3'b010: w_legal = 1'b1;
         3'b100, 3'b101:         w_legal = !i_req_is_store;
         default:                w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_aligned = 1'b1;
      case (i_req_funct3[1:0])
         2'b01:   w_aligned = !i_req_address[0];
         2'b10:   w_aligned = (i_req_address[1:0] == 2'b00);
         default: w_aligned = 1'b1;
      endcase
   end

   // Stores replicate the datum across lanes; byte enables select the target lanes.
   always_comb begin
      w_byte_en    = 4'b0000;
      w_write_data = '0;
      if (i_req_is_store) begin
         case (i_req_funct3[1:0])
            2'b00: begin
               w_byte_en    = 4'b0001 << i_req_address[1:0];
               w_write_data = {4{i_req_store_data[7:0]}};
            end
            2'b01: begin
               w_byte_en    = 4'b0011 << i_req_address[1:0];
               w_write_data = {2{i_req_store_data[15:0]}};
            end
            default: begin
               w_byte_en    = 4'b1111;
               w_write_data = i_req_store_data;
            end
         endcase
      end
   end

   assign w_shifted = i_mem_read_data >> {r_off, 3'b000};

   always_comb begin
      w_load_value = w_shifted;
      case (r_funct3)
         3'b000:  w_load_value = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_load_value = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b100:  w_load_value = {24'b0, w_shifted[7:0]};
         3'b101:  w_load_value = {16'b0, w_shifted[15:0]};
         default: w_load_value = w_shifted;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state          <= StIdle;
         r_req_ready      <= 1'b1;
         r_mem_valid      <= 1'b0;
         r_mem_address    <= '0;
         r_mem_write_en   <= 1'b0;
         r_mem_byte_en    <= 4'b0000;
         r_mem_write_data <= '0;
         r_result_valid   <= 1'b0;
         r_result_rd      <= '0;
         r_result_data    <= '0;
         r_store_done     <= 1'b0;
         r_fault          <= 1'b0;
         r_is_store       <= 1'b0;
         r_funct3         <= 3'b000;
         r_off            <= 2'b00;
         r_rd             <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (i_req_valid) begin
                  r_is_store  <= i_req_is_store;
                  r_funct3    <= i_req_funct3;
                  r_off       <= i_req_address[1:0];
                  r_rd        <= i_req_rd;
                  r_req_ready <= 1'b0;
                  if (w_legal && w_aligned) begin
                     r_state          <= StMemReq;
                     r_mem_valid      <= 1'b1;
                     r_mem_address    <= {i_req_address[REGISTER_WIDTH-1:2], 2'b00};
                     r_mem_write_en   <= i_req_is_store;
                     r_mem_byte_en    <= w_byte_en;
                     r_mem_write_data <= w_write_data;
                  end else begin
                     r_state <= StResp;
                     r_fault <= 1'b1;
                  end
               end
            end
            StMemReq: begin
               if (i_mem_ready) begin
                  r_mem_valid      <= 1'b0;
                  r_mem_address    <= '0;
                  r_mem_write_en   <= 1'b0;
                  r_mem_byte_en    <= 4'b0000;
                  r_mem_write_data <= '0;
                  if (r_is_store) begin
                     r_state      <= StResp;
                     r_store_done <= 1'b1;
                  end else begin
                     r_state <= StWaitRd;
                  end
               end
            end
            StWaitRd: begin
               if (i_mem_read_valid) begin
                  r_state        <= StResp;
                  r_result_valid <= 1'b1;
                  r_result_rd    <= r_rd;
                  r_result_data  <= w_load_value;
               end
            end
            StResp: begin
               r_state        <= StIdle;
               r_result_valid <= 1'b0;
               r_result_rd    <= '0;
               r_result_data  <= '0;
               r_store_done   <= 1'b0;
               r_fault        <= 1'b0;
               r_req_ready    <= 1'b1;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_req_ready      = r_req_ready;
   assign o_stall          = !r_req_ready;
   assign o_mem_valid      = r_mem_valid;
   assign o_mem_address    = r_mem_address;
   assign o_mem_write_en   = r_mem_write_en;
   assign o_mem_byte_en    = r_mem_byte_en;
   assign o_mem_write_data = r_mem_write_data;
   assign o_result_valid   = r_result_valid;
   assign o_result_rd      = r_result_rd;
   assign o_result_data    = r_result_data;
   assign o_store_done     = r_store_done;
   assign o_fault          = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios with literal expectations plus a randomized
// run, all checked every cycle against a transaction-level reference model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_address, req_store_data;
   logic [4:0]  req_rd;
   logic        mem_ready, mem_read_valid;
   logic [31:0] mem_read_data;
   logic        req_ready, mem_valid, mem_write_en, result_valid, store_done, fault, stall;
   logic [31:0] mem_address, mem_write_data, result_data;
   logic [3:0]  mem_byte_en;
   logic [4:0]  result_rd;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   load_store_unit #(.REGISTER_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_is_store(req_is_store),
      .i_req_funct3(req_funct3), .i_req_address(req_address),
      .i_req_store_data(req_store_data), .i_req_rd(req_rd),
      .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_address(mem_address),
      .o_mem_write_en(mem_write_en), .o_mem_byte_en(mem_byte_en),
      .o_mem_write_data(mem_write_data), .i_mem_read_data(mem_read_data),
      .i_mem_read_valid(mem_read_valid), .o_result_valid(result_valid),
      .o_result_rd(result_rd), .o_result_data(result_data), .o_store_done(store_done),
      .o_fault(fault), .o_stall(stall)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model: plain arithmetic on access size ----------------
   function automatic int unsigned acc_size(input logic [2:0] f3);
      return 32'd1 << f3[1:0];
   endfunction

   function automatic bit is_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      return !legal || ((a % acc_size(f3)) != 0);
   endfunction

   function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r;
      int unsigned sz;
      sz = acc_size(f3);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [3:0] lane_en(input logic [2:0] f3, input logic [1:0] off);
      int unsigned m;
      m = ((32'd1 << acc_size(f3)) - 1) << off;
      return m[3:0];
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
      int unsigned v, sz, mask;
      sz = acc_size(f3);
      v  = word >> (8 * off);
      if (sz < 4) begin
         mask = (32'd1 << (8 * sz)) - 1;
         v = v & mask;
         if (!f3[2] && (((v >> (8 * sz - 1)) & 1) == 1)) v = v | ~mask;
      end
      return v;
   endfunction

   // Transaction timeline: 0 = presenting to memory, 1 = awaiting read data, 2 = response.
   bit          m_started = 0, m_busy = 0, m_store, m_fault;
   int          m_phase;
   logic [31:0] m_addr, m_wd, m_data;
   logic [3:0]  m_be;
   logic [4:0]  m_rd;
   logic [2:0]  m_f3;
   logic [1:0]  m_off;
   bit          e_ready, e_mv, e_pulse;

   always @(negedge clk) begin
      e_ready = !m_busy;
      e_mv    = m_busy && m_phase == 0;
      e_pulse = m_busy && m_phase == 2;
      if (m_started) begin
         check("req_ready", req_ready, e_ready);
         check("stall", stall, !e_ready);
         check("mem_valid", mem_valid, e_mv);
         check("result_valid", result_valid, e_pulse && !m_fault && !m_store);
         check("store_done", store_done, e_pulse && !m_fault && m_store);
         check("fault", fault, e_pulse && m_fault);
         if (e_mv) begin
            check("mem_address", mem_address, m_addr);
            check("mem_write_en", mem_write_en, m_store);
            check("mem_byte_en", mem_byte_en, m_be);
            check("mem_write_data", mem_write_data, m_wd);
         end
         if (e_pulse && !m_fault && !m_store) begin
            check("result_data", result_data, m_data);
            check("result_rd", result_rd, m_rd);
         end
      end
      if (!rst) begin
         m_busy    = 0;
         m_started = 1;
      end else if (m_started) begin
         if (e_pulse) m_busy = 0;
         else if (m_busy && m_phase == 1 && mem_read_valid) begin
            m_data  = load_val(m_f3, m_off, mem_read_data);
            m_phase = 2;
         end else if (m_busy && m_phase == 0 && mem_ready) m_phase = m_store ? 2 : 1;
         else if (!m_busy && req_valid) begin
            m_busy  = 1;
            m_store = req_is_store;
            m_f3    = req_funct3;
            m_off   = req_address[1:0];
            m_rd    = req_rd;
            m_fault = is_fault(req_is_store, req_funct3, req_address);
            m_addr  = req_address & 32'hFFFF_FFFC;
            m_be    = req_is_store ? lane_en(req_funct3, req_address[1:0]) : 4'b0000;
            m_wd    = req_is_store ? lane_data(req_funct3, req_store_data) : 32'h0;
            m_phase = m_fault ? 2 : 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic put_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] rd);
      req_valid = 1; req_is_store = st; req_funct3 = f3;
      req_address = a; req_store_data = d; req_rd = rd;
   endtask

   // Zero-wait load: accept N, mem_valid N+1, read_valid N+2, result N+3.
   task automatic zero_wait_load(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] word, input logic [4:0] rd,
                                 input logic [31:0] exp);
      tick; put_req(0, f3, a, 32'h0, rd); mem_ready = 1;
      tick; req_valid = 0;
      @(negedge clk);
      check("ld_mem_address", mem_address, a & 32'hFFFF_FFFC);
      check("ld_byte_en", mem_byte_en, 4'b0000);
      tick; mem_read_valid = 1; mem_read_data = word; mem_ready = 0;
      @(negedge clk);
      check("ld_early_result", result_valid, 1'b0);
      tick; mem_read_valid = 0;
      @(negedge clk);
      check("ld_result_valid", result_valid, 1'b1);
      check("ld_result_data", result_data, exp);
      check("ld_result_rd", result_rd, rd);
   endtask

   task automatic fault_case(input bit st, input logic [2:0] f3, input logic [31:0] a);
      tick; put_req(st, f3, a, 32'h1111_2222, 5'd3); mem_ready = 1;
      tick; req_valid = 0;
      @(negedge clk);
      check("flt_pulse", fault, 1'b1);
      check("flt_no_mem", mem_valid, 1'b0);
      tick;
      @(negedge clk);
      check("flt_ready_after", req_ready, 1'b1);
      check("flt_no_mem_after", mem_valid, 1'b0);
   endtask

   initial begin
      rst = 0; req_valid = 0; req_is_store = 0; req_funct3 = 0; req_address = 0;
      req_store_data = 0; req_rd = 0; mem_ready = 0; mem_read_valid = 0; mem_read_data = 0;

      // Reset, then abort a load mid-flight.
      tick; tick; rst = 1;
      @(negedge clk);
      check("rst_ready", req_ready, 1'b1);
      check("rst_mem_valid", mem_valid, 1'b0);
      check("rst_result", result_valid, 1'b0);
      tick; put_req(0, 3'b010, 32'h0000_0100, 32'h0, 5'd9); mem_ready = 1;
      tick; req_valid = 0;
      @(negedge clk);
      check("abort_mem_valid", mem_valid, 1'b1);
      tick; rst = 0; mem_ready = 0;
      tick; rst = 1; mem_read_valid = 1; mem_read_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("abort_ready", req_ready, 1'b1);
      check("abort_mem_off", mem_valid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick;
         @(negedge clk);
         check("abort_no_result", result_valid, 1'b0);
      end
      tick; mem_read_valid = 0;

      // LB / LBU at 0x1003.
      zero_wait_load(3'b000, 32'h0000_1003, 32'h80FF_1234, 5'd7, 32'hFFFF_FF80);
      zero_wait_load(3'b100, 32'h0000_1003, 32'h80FF_1234, 5'd8, 32'h0000_0080);

      // SH at 0x2002.
      tick; put_req(1, 3'b001, 32'h0000_2002, 32'hCAFE_BABE, 5'd0); mem_ready = 1;
      tick; req_valid = 0;
      @(negedge clk);
      check("sh_write_en", mem_write_en, 1'b1);
      check("sh_byte_en", mem_byte_en, 4'b1100);
      check("sh_write_data", mem_write_data, 32'hBABE_BABE);
      check("sh_address", mem_address, 32'h0000_2000);
      tick; mem_ready = 0;
      @(negedge clk);
      check("sh_store_done", store_done, 1'b1);

      // SW held off by mem_ready for 5 cycles, with a competing request.
      tick; put_req(1, 3'b010, 32'h0000_3000, 32'h1234_5678, 5'd0); mem_ready = 0;
      for (int k = 0; k < 5; k++) begin
         tick;
         if (k == 0) req_valid = 0;
         else put_req(0, 3'b010, 32'h0000_0040, 32'h0, 5'd4);
         @(negedge clk);
         check("sw_hold_valid", mem_valid, 1'b1);
         check("sw_hold_addr", mem_address, 32'h0000_3000);
         check("sw_hold_data", mem_write_data, 32'h1234_5678);
         check("sw_hold_be", mem_byte_en, 4'b1111);
         check("sw_hold_stall", stall, 1'b1);
      end
      tick; req_valid = 0; mem_ready = 1;
      @(negedge clk);
      check("sw_no_early_done", store_done, 1'b0);
      tick; mem_ready = 0;
      @(negedge clk);
      check("sw_store_done", store_done, 1'b1);
      tick;
      @(negedge clk);
      check("sw_ready_after", req_ready, 1'b1);
      check("sw_second_ignored", mem_valid, 1'b0);

      // Misaligned LW and illegal store width.
      fault_case(0, 3'b010, 32'h0000_4002);
      fault_case(1, 3'b011, 32'h0000_4000);

      // Back-to-back LHU then LH.
      zero_wait_load(3'b101, 32'h0000_5002, 32'h8001_0000, 5'd11, 32'h0000_8001);
      zero_wait_load(3'b001, 32'h0000_5002, 32'h8001_0000, 5'd12, 32'hFFFF_8001);

      // Randomized traffic with a random-latency memory and occasional resets.
      for (int c = 0; c < 4000; c++) begin
         tick;
         rst            = ($urandom_range(0, 199) != 0);
         req_valid      = $urandom_range(0, 1);
         req_is_store   = $urandom_range(0, 1);
         req_funct3     = 3'($urandom_range(0, 7));
         req_address    = $urandom;
         req_store_data = $urandom;
         req_rd         = 5'($urandom_range(0, 31));
         mem_ready      = ($urandom_range(0, 2) != 0);
         mem_read_valid = ($urandom_range(0, 2) == 0);
         mem_read_data  = $urandom;
      end
      tick; rst = 1; req_valid = 0; mem_ready = 1; mem_read_valid = 1;
      repeat (6) tick;
      mem_ready = 0; mem_read_valid = 0;
      repeat (2) tick;
      @(negedge clk);
      check("drain_ready", req_ready, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage, directly downstream of execute.
- Consumes effective address, store data, funct3 and rd for LOAD/STORE instructions.
- Drives a valid/ready data-memory port, and returns aligned, sign- or zero-extended load results to the register-file write mux.
- Reports misaligned or illegal accesses and exposes a stall that freezes fetch while an access is in flight.

Parameters:
REGISTER_WIDTH, 32, data and address width (fixed 32; byte-lane logic assumes 4 lanes)
REG_ADDR_WIDTH, 5, width of rd

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
req_valid  in  1  execute presents a load/store
req_ready  out  1  LSU idle, request accepted when req_valid&req_ready
req_is_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_address  in  32  effective address (rs1+imm)
req_store_data  in  32  rs2 value
req_rd  in  5  load destination
mem_valid  out  1  memory request valid
mem_ready  in  1  memory accepts request
mem_address  out  32  word-aligned address ({addr[31:2],2'b00})
mem_write_en  out  1  1=write
mem_byte_en  out  4  write lane enables
mem_write_data  out  32  lane-replicated store data
mem_read_data  in  32  raw read word
mem_read_valid  in  1  read data valid
result_valid  out  1  one-cycle pulse, load result ready
result_rd  out  5  destination of result
result_data  out  32  extended load value
store_done  out  1  one-cycle pulse, store committed
fault  out  1  one-cycle pulse, misaligned/illegal access
stall  out  1  equals ~req_ready

Behaviour:
- Reset (rst=0 at edge): state IDLE; all outputs 0 except req_ready=1. Reset mid-access aborts the access. mem_valid drops at that edge. A later mem_read_valid is ignored.
- States: IDLE, MEM_REQ, WAIT_RD, RESP.
- IDLE: req_ready=1. On accept, register is_store, funct3, address[1:0], rd and store data.
  - Legal and aligned -> MEM_REQ.
  - Otherwise -> RESP with fault flagged and no memory access.
- Legality:
  - Loads accept funct3 000/001/010/100/101.
  - Stores accept 000/001/010.
  - Any other code is illegal.
- Alignment:
  - H/HU require addr[0]=0.
  - W requires addr[1:0]=00.
- MEM_REQ: mem_valid=1. Address, write_en, byte_en and write_data stay stable until mem_ready=1.
  - On handshake, a store -> RESP.
  - On handshake, a load -> WAIT_RD.
- WAIT_RD: wait indefinitely for mem_read_valid. On it, capture the extracted value -> RESP.
  - mem_read_valid is ignored in every other state, including the handshake cycle itself.
- RESP: exactly one of result_valid, store_done or fault pulses for this cycle -> IDLE.
  - A new request is accepted no earlier than the following cycle.
- Store lanes, off=addr[1:0]:
  - SB: byte_en=4'b0001<<off, data={4{d[7:0]}}.
  - SH: byte_en=4'b0011<<off, data={2{d[15:0]}}.
  - SW: byte_en=4'b1111, data=d.
- Loads: mem_byte_en=0 and mem_write_data=0. The word is shifted right by off*8. B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
- Loads with rd=0 still produce result_valid with result_rd=0; the register file discards them.
- Latency with a zero-wait memory (mem_ready=1 in the same cycle, read_valid one cycle later), accept at cycle N:
  - Load: mem_valid N+1, read_valid N+2, result_valid N+3.
  - Store: store_done N+2.
  - Fault: fault N+1.
- req_valid while busy is not accepted and has no effect.

Test Plan:
1. Reset with rst=0 for 2 cycles, then mid-load assert rst=0 for 1 cycle -> all outputs 0, req_ready=1; a subsequent mem_read_valid=1 with data 0xDEADBEEF produces no result_valid.
2. LB at 0x1003, memory word 0x80FF_1234, zero-wait memory -> mem_address=0x1000; result_valid at accept+3 with result_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
3. SH at 0x2002, rs2=0xCAFE_BABE -> mem_write_en=1, mem_byte_en=4'b1100, mem_write_data=0xBABE_BABE; store_done at accept+2.
4. mem_ready held 0 for 5 cycles on SW 0x3000 -> mem_valid, address, data and byte_en stable all 5 cycles; stall=1; a second req_valid is not accepted; store_done is 1 cycle after mem_ready rises.
5. LW at 0x4002 and SW with funct3=011 -> fault pulses at accept+1; mem_valid never asserts; req_ready=1 at accept+2.
6. Back-to-back LHU 0x5002 (word 0x8001_0000) then LH 0x5002 -> result_data 0x00008001 then 0xFFFF8001, with result_rd matching each request.
